// File: rtl/change_dispenser_if.sv
// Handshake and solenoid bundle between the vend-control FSM (master)
// and the change dispenser (slave).
//   start/amount/abort : request side, driven by the vend controller
//   busy/done          : dispense status back to the vend controller
//   coin_q/coin_d/coin_n : one solenoid pulse per released coin
//   residual/dispensed : cents left undispensed / cents issued so far
interface change_dispenser_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [CNT_W-1:0] amount;
  logic             abort;
  logic             busy;
  logic             done;
  logic             coin_q;
  logic             coin_d;
  logic             coin_n;
  logic [CNT_W-1:0] residual;
  logic [CNT_W-1:0] dispensed;

  modport master (
    output start, amount, abort,
    input  busy, done, coin_q, coin_d, coin_n, residual, dispensed
  );

  modport slave (
    input  start, amount, abort,
    output busy, done, coin_q, coin_d, coin_n, residual, dispensed
  );
endinterface

// File: rtl/change_dispenser.sv
// Change-return engine: counts the owed amount down greedily in
// quarter/dime/nickel steps and fires one solenoid pulse per coin.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-low
//   bus   : change_dispenser_if.slave (start/amount/abort in;
//           busy/done/coin_*/residual/dispensed out, all registered)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; amount latched on acceptance
// S_SELECT | one cycle: pick largest coin <= remaining, or finish
// S_PULSE  | selected coin line high for PULSE_CYC cycles
// S_GAP    | all coin lines low for GAP_CYC cycles
// S_DONE   | one-cycle done strobe, residual published
module change_dispenser #(
  parameter int CNT_W     = 8,
  parameter int VAL_Q     = 25,
  parameter int VAL_D     = 10,
  parameter int VAL_N     = 5,
  parameter int PULSE_CYC = 4,
  parameter int GAP_CYC   = 2
) (
  input logic               clk,
  input logic               reset,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {S_IDLE, S_SELECT, S_PULSE, S_GAP, S_DONE} state_t;

  localparam int TMAX  = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int TMR_W = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [CNT_W-1:0] V_Q = CNT_W'(VAL_Q);
  localparam logic [CNT_W-1:0] V_D = CNT_W'(VAL_D);
  localparam logic [CNT_W-1:0] V_N = CNT_W'(VAL_N);

  // Timer holds "cycles left minus one", so it terminates on zero.
  localparam logic [TMR_W-1:0] T_PULSE = TMR_W'(PULSE_CYC - 1);
  localparam logic [TMR_W-1:0] T_GAP   = TMR_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] remaining;
  logic [TMR_W-1:0] tmr;
  logic             abort_pend;
  logic             busy_r;
  logic             done_r;
  logic             coin_q_r;
  logic             coin_d_r;
  logic             coin_n_r;
  logic [CNT_W-1:0] residual_r;
  logic [CNT_W-1:0] dispensed_r;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      remaining   <= '0;
      tmr         <= '0;
      abort_pend  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      coin_q_r    <= 1'b0;
      coin_d_r    <= 1'b0;
      coin_n_r    <= 1'b0;
      residual_r  <= '0;
      dispensed_r <= '0;
    end else begin
      done_r <= 1'b0;
      case (state)
        S_IDLE: begin
          // start wins over abort here; abort is meaningless in IDLE
          if (bus.start) begin
            remaining   <= bus.amount;
            dispensed_r <= '0;
            residual_r  <= '0;
            abort_pend  <= 1'b0;
            busy_r      <= 1'b1;
            state       <= S_SELECT;
          end
        end

        S_SELECT: begin
          if (bus.abort || remaining < V_N) begin
            done_r     <= 1'b1;
            residual_r <= remaining;
            state      <= S_DONE;
          end else begin
            tmr   <= T_PULSE;
            state <= S_PULSE;
            if (remaining >= V_Q) begin
              coin_q_r    <= 1'b1;
              remaining   <= remaining - V_Q;
              dispensed_r <= dispensed_r + V_Q;
            end else if (remaining >= V_D) begin
              coin_d_r    <= 1'b1;
              remaining   <= remaining - V_D;
              dispensed_r <= dispensed_r + V_D;
            end else begin
              coin_n_r    <= 1'b1;
              remaining   <= remaining - V_N;
              dispensed_r <= dispensed_r + V_N;
            end
          end
        end

        S_PULSE: begin
          if (tmr == '0) begin
            coin_q_r <= 1'b0;
            coin_d_r <= 1'b0;
            coin_n_r <= 1'b0;
            // An abort seen anywhere in the pulse lets the coin finish
            // dropping, then skips the gap.
            if (abort_pend || bus.abort) begin
              done_r     <= 1'b1;
              residual_r <= remaining;
              state      <= S_DONE;
            end else if (GAP_CYC == 0) begin
              state <= S_SELECT;
            end else begin
              tmr   <= T_GAP;
              state <= S_GAP;
            end
          end else begin
            tmr <= tmr - TMR_W'(1);
            if (bus.abort) abort_pend <= 1'b1;
          end
        end

        S_GAP: begin
          if (bus.abort) begin
            done_r     <= 1'b1;
            residual_r <= remaining;
            state      <= S_DONE;
          end else if (tmr == '0) begin
            state <= S_SELECT;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end

        S_DONE: begin
          busy_r <= 1'b0;
          state  <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.coin_q    = coin_q_r;
  assign bus.coin_d    = coin_d_r;
  assign bus.coin_n    = coin_n_r;
  assign bus.residual  = residual_r;
  assign bus.dispensed = dispensed_r;

endmodule

// File: tb/tb_change_dispenser.sv
module tb_change_dispenser;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  change_dispenser_if #(.CNT_W(8)) bus ();

  change_dispenser dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // per-cycle traces of the last dispense (cycle 0 = start sampled)
  logic tq [0:63];
  logic td [0:63];
  logic tn [0:63];
  logic tb_busy [0:63];
  logic tb_done [0:63];
  int   done_cyc;
  int   nq, nd, nn;
  int   hq, hn;
  int   overlap;
  logic [7:0] res_at_done;
  logic [7:0] dsp_at_done;
  logic post_busy;
  logic post_done;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus/capture only: issue start at cycle 0, optional abort/restart,
  // record outputs until done (bounded) plus one cycle after.
  task automatic run(input logic [7:0] amt, input logic abort0,
                     input int abort_at, input int restart_at,
                     input logic [7:0] re_amt);
    logic pq, pd, pn;
    int   cnt;
    pq = 0; pd = 0; pn = 0;
    nq = 0; nd = 0; nn = 0; hq = 0; hn = 0; overlap = 0;
    done_cyc = -1;
    for (int i = 0; i < 64; i++) begin
      tq[i] = 0; td[i] = 0; tn[i] = 0; tb_busy[i] = 0; tb_done[i] = 0;
    end
    step();
    bus.start  = 1'b1;
    bus.amount = amt;
    bus.abort  = abort0;
    for (int c = 1; c < 400 && done_cyc < 0; c++) begin
      step();
      bus.start = (c == restart_at);
      if (c == restart_at) bus.amount = re_amt;
      bus.abort = (c == abort_at);
      if (c < 64) begin
        tq[c] = bus.coin_q; td[c] = bus.coin_d; tn[c] = bus.coin_n;
        tb_busy[c] = bus.busy; tb_done[c] = bus.done;
      end
      if (bus.coin_q && !pq) nq++;
      if (bus.coin_d && !pd) nd++;
      if (bus.coin_n && !pn) nn++;
      if (bus.coin_q) hq++;
      if (bus.coin_n) hn++;
      cnt = int'(bus.coin_q) + int'(bus.coin_d) + int'(bus.coin_n);
      if (cnt > 1) overlap++;
      pq = bus.coin_q; pd = bus.coin_d; pn = bus.coin_n;
      if (bus.done) begin
        done_cyc    = c;
        res_at_done = bus.residual;
        dsp_at_done = bus.dispensed;
      end
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    step();
    post_busy = bus.busy;
    post_done = bus.done;
  endtask

  task automatic test_reset();
    int bad;
    repeat (3) step();
    checks++;
    if ({bus.busy, bus.done, bus.coin_q, bus.coin_d, bus.coin_n} !== 5'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {bus.busy, bus.done, bus.coin_q, bus.coin_d, bus.coin_n});
    end
    checks++;
    if (bus.residual !== 8'd0 || bus.dispensed !== 8'd0) begin
      errors++;
      $display("FAIL reset_counts residual %0d dispensed %0d want 0 0",
               bus.residual, bus.dispensed);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b want 0", bus.busy);
    end
    // reset while a quarter pulse is active
    bus.start  = 1'b1;
    bus.amount = 8'd25;
    step();
    bus.start = 1'b0;
    step();
    checks++;
    if (bus.coin_q !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_coin_q got %b want 1", bus.coin_q);
    end
    #3 reset = 1'b0;
    #1;
    checks++;
    if (bus.coin_q !== 1'b0 || bus.busy !== 1'b0 || bus.dispensed !== 8'd0) begin
      errors++;
      $display("FAIL async_reset coin_q %b busy %b dispensed %0d want 0 0 0",
               bus.coin_q, bus.busy, bus.dispensed);
    end
    step();
    step();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.coin_q || bus.coin_d || bus.coin_n || bus.busy || bus.done) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL post_reset_idle active_cycles %0d want 0", bad);
    end
  endtask

  task automatic test_amount_40();
    int bad;
    run(8'd40, 1'b0, -1, -1, 8'd0);
    checks++;
    if (done_cyc != 23) begin
      errors++;
      $display("FAIL a40_done_cycle got %0d want 23", done_cyc);
    end
    checks++;
    if (res_at_done !== 8'd0 || dsp_at_done !== 8'd40) begin
      errors++;
      $display("FAIL a40_totals residual %0d dispensed %0d want 0 40",
               res_at_done, dsp_at_done);
    end
    bad = 0;
    for (int c = 1; c <= 23; c++) begin
      if (tq[c] !== (c >= 2 && c <= 5))   bad++;
      if (td[c] !== (c >= 9 && c <= 12))  bad++;
      if (tn[c] !== (c >= 16 && c <= 19)) bad++;
      if (tb_busy[c] !== 1'b1) bad++;
      if (tb_done[c] !== (c == 23)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL a40_waveform wrong_samples %0d want 0", bad);
    end
    checks++;
    if (post_busy !== 1'b0 || post_done !== 1'b0) begin
      errors++;
      $display("FAIL a40_after_done busy %b done %b want 0 0", post_busy, post_done);
    end
  endtask

  task automatic test_amount_255();
    run(8'd255, 1'b0, -1, -1, 8'd0);
    checks++;
    if (nq != 10 || nd != 0 || nn != 1) begin
      errors++;
      $display("FAIL a255_coins q %0d d %0d n %0d want 10 0 1", nq, nd, nn);
    end
    checks++;
    if (hq != 40 || hn != 4) begin
      errors++;
      $display("FAIL a255_pulse_len q_cycles %0d n_cycles %0d want 40 4", hq, hn);
    end
    checks++;
    if (done_cyc != 79 || res_at_done !== 8'd0 || dsp_at_done !== 8'd255) begin
      errors++;
      $display("FAIL a255_done cycle %0d residual %0d dispensed %0d want 79 0 255",
               done_cyc, res_at_done, dsp_at_done);
    end
    checks++;
    if (overlap != 0) begin
      errors++;
      $display("FAIL a255_onehot overlaps %0d want 0", overlap);
    end
  endtask

  task automatic test_small_amounts();
    run(8'd3, 1'b0, -1, -1, 8'd0);
    checks++;
    if (done_cyc != 2 || res_at_done !== 8'd3 || dsp_at_done !== 8'd0 ||
        (nq + nd + nn) != 0) begin
      errors++;
      $display("FAIL a3 cycle %0d residual %0d dispensed %0d coins %0d want 2 3 0 0",
               done_cyc, res_at_done, dsp_at_done, nq + nd + nn);
    end
    run(8'd0, 1'b0, -1, -1, 8'd0);
    checks++;
    if (done_cyc != 2 || res_at_done !== 8'd0 || (nq + nd + nn) != 0) begin
      errors++;
      $display("FAIL a0 cycle %0d residual %0d coins %0d want 2 0 0",
               done_cyc, res_at_done, nq + nd + nn);
    end
  endtask

  task automatic test_abort();
    int bad;
    run(8'd60, 1'b0, 3, -1, 8'd0);
    checks++;
    if (done_cyc != 6 || res_at_done !== 8'd35 || dsp_at_done !== 8'd25) begin
      errors++;
      $display("FAIL abort60 cycle %0d residual %0d dispensed %0d want 6 35 25",
               done_cyc, res_at_done, dsp_at_done);
    end
    bad = 0;
    for (int c = 1; c <= 6; c++) begin
      if (tq[c] !== (c >= 2 && c <= 5)) bad++;
      if (td[c] !== 1'b0 || tn[c] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0 || nq != 1) begin
      errors++;
      $display("FAIL abort60_pulse wrong_samples %0d quarters %0d want 0 1", bad, nq);
    end
  endtask

  task automatic test_back_to_back();
    run(8'd15, 1'b0, -1, 3, 8'd10);
    checks++;
    if (nq != 0 || nd != 1 || nn != 1 || res_at_done !== 8'd0 ||
        dsp_at_done !== 8'd15 || done_cyc != 16) begin
      errors++;
      $display("FAIL busy_restart q %0d d %0d n %0d residual %0d dispensed %0d cycle %0d want 0 1 1 0 15 16",
               nq, nd, nn, res_at_done, dsp_at_done, done_cyc);
    end
    run(8'd10, 1'b1, -1, -1, 8'd0);
    checks++;
    if (nd != 1 || nq != 0 || nn != 0 || done_cyc != 9 ||
        res_at_done !== 8'd0 || dsp_at_done !== 8'd10) begin
      errors++;
      $display("FAIL start_abort_idle d %0d q %0d n %0d cycle %0d residual %0d dispensed %0d want 1 0 0 9 0 10",
               nd, nq, nn, done_cyc, res_at_done, dsp_at_done);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.amount = 8'd0;
    test_reset();
    test_amount_40();
    test_amount_255();
    test_small_amounts();
    test_abort();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Down-counting change-return engine for the vending machine.
- Complements the up-counting coin accumulator: takes the change amount owed, counts it down in quarter/dime/nickel steps (greedy, largest first), and drives one coin-release solenoid pulse per coin.
- Sits between the vend-control FSM (start/abort/done handshake) and the coin-return solenoids.

Parameters:
- CNT_W, 8, width of amount, residual and dispensed (cents).
- VAL_Q, 25, quarter value in cents.
- VAL_D, 10, dime value in cents.
- VAL_N, 5, nickel value in cents.
- PULSE_CYC, 4, solenoid pulse length in clk cycles (>=1).
- GAP_CYC, 2, idle cycles after each pulse (>=0; 0 = no GAP state).
- Legal values require VAL_Q > VAL_D > VAL_N > 0.

Ports:
- clk, input, 1, system clock, rising edge.
- reset, input, 1, asynchronous, active-low reset (0 = reset).
- start, input, 1, request a dispense; sampled only in IDLE.
- amount, input, CNT_W, change owed in cents; latched when start is accepted.
- abort, input, 1, stop dispensing early; ignored in IDLE.
- busy, output, 1, high from the cycle after start is accepted through the DONE cycle, inclusive.
- done, output, 1, single-cycle completion strobe.
- coin_q, output, 1, quarter solenoid pulse.
- coin_d, output, 1, dime solenoid pulse.
- coin_n, output, 1, nickel solenoid pulse.
- residual, output, CNT_W, amount left undispensed; valid from done, held until next accepted start.
- dispensed, output, CNT_W, running sum of coin values issued; cleared on accepted start.

Behaviour:
- All outputs are registered.
- Reset (reset=0, asynchronous): state IDLE; busy, done, coin_q/d/n = 0; residual = 0; dispensed = 0; internal remaining and timer counters = 0.
- Reset asserted mid-pulse drops the coin line immediately; no pulse resumes after release.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - start=1 latches remaining=amount, clears dispensed, goes to SELECT.
  - Otherwise stays in IDLE.
  - If start and abort are both high in IDLE, start wins.
- SELECT (1 cycle), greedy choice on remaining:
  - remaining >= VAL_Q: choose Q.
  - else remaining >= VAL_D: choose D.
  - else remaining >= VAL_N: choose N.
  - else go to DONE.
  - On a coin choice: remaining -= coin value, dispensed += coin value, go to PULSE.
  - Arithmetic is unsigned, CNT_W wide; subtraction only when remaining >= coin value, so no underflow.
- PULSE:
  - Exactly one selected coin line is high for exactly PULSE_CYC consecutive cycles; then GAP, or SELECT if GAP_CYC=0.
  - At most one coin line is ever high.
- GAP: all coin lines low for GAP_CYC cycles, then SELECT.
- DONE (1 cycle):
  - done=1, residual=remaining, busy=1; next state IDLE.
  - start is not accepted in DONE; it is accepted from the following IDLE cycle.
- Latency: start sampled at cycle 0 → SELECT at cycle 1 → first coin line high at cycle 2.
- Abort:
  - In SELECT or GAP: next state is DONE.
  - In PULSE: the current pulse completes its full PULSE_CYC, then DONE (the gap is skipped).
  - residual reflects all coins not yet selected.
- start while busy: ignored; amount is not re-latched.
- amount not a multiple of VAL_N: the leftover (< VAL_N) appears on residual.
- amount = 0: SELECT → DONE, done at cycle 2 with residual 0 and no pulses.

Test Plan:
- Reset/idle: hold reset=0, then release → all outputs 0, busy=0; a 2-cycle reset=0 pulse while coin_q is high drops coin_q in the same cycle, and the block returns to IDLE.
- amount=40, start at cycle 0 (defaults):
  - coin_q high cycles 2-5, coin_d high 9-12, coin_n high 16-19.
  - done high at cycle 23 with residual=0, dispensed=40.
  - busy high cycles 1-23.
- amount=255: 10 quarter pulses then 1 nickel pulse, no dimes → done with residual=0, dispensed=255.
- amount=3 → no coin pulses; done at cycle 2 with residual=3, dispensed=0.
- amount=60, abort asserted at cycle 3 (mid first quarter pulse):
  - coin_q completes cycles 2-5.
  - done at cycle 6 with residual=35, dispensed=25.
- start re-pulsed with amount=10 while busy on amount=15 → ignored (one dime + one nickel, residual 0); the same cycle start+abort in IDLE starts a dispense normally.
